// File: rtl/batter_led_scan_if.sv
// Bus between the at-bat logic and the batter result display.
// The master side drives results and clear; the slave side drives the LED pins.
interface batter_led_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4:0]            hitout;
    logic                  hit_valid;
    logic                  clear;
    logic [7:0]            batter_led;
    logic [NUM_DIGITS-1:0] dig_n;
    logic                  err;

    modport master (
        output hitout, hit_valid, clear,
        input  batter_led, dig_n, err
    );

    modport slave (
        input  hitout, hit_valid, clear,
        output batter_led, dig_n, err
    );
endinterface

// File: rtl/batter_led_scan.sv
// Multiplexed batter-result display: keeps a shift history of the last
// NUM_DIGITS results, scans a common-anode seven-segment bank, and blinks
// the newest result for BLINK_PERIODS off/on periods after it arrives.
module batter_led_scan #(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV      = 1000,
    parameter int BLINK_DIV     = 2500000,
    parameter int BLINK_PERIODS = 3
) (
    input logic               clk,
    input logic               rst_n,
    batter_led_scan_if.slave  bus
);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int HALF_W  = $clog2(2 * BLINK_PERIODS + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [HALF_W-1:0]  HALF_LOAD  = HALF_W'(2 * BLINK_PERIODS);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // Result codes: 0 blank, 1..4 hit1..hit4, 5 out.
    function automatic logic [7:0] glyph(input logic [2:0] code);
        case (code)
            3'd1:    glyph = 8'b10011111;
            3'd2:    glyph = 8'b00100101;
            3'd3:    glyph = 8'b00001101;
            3'd4:    glyph = 8'b10010001;
            3'd5:    glyph = 8'b00000011;
            default: glyph = 8'b11111111;
        endcase
    endfunction

    // Only called with a one-hot vector; bit 4 is hit1, bit 0 is out.
    function automatic logic [2:0] encode(input logic [4:0] h);
        if (h[4])      encode = 3'd1;
        else if (h[3]) encode = 3'd2;
        else if (h[2]) encode = 3'd3;
        else if (h[1]) encode = 3'd4;
        else           encode = 3'd5;
    endfunction

    logic [2:0]            hist_q [NUM_DIGITS];
    logic [2:0]            hist_d [NUM_DIGITS];
    logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic [HALF_W-1:0]     half_q, half_d;
    logic [7:0]            led_q, led_d;
    logic [NUM_DIGITS-1:0] dig_n_q, dig_n_d;
    logic                  err_q, err_d;

    logic accept;
    logic invalid;
    logic blink_off;

    assign accept    = bus.hit_valid && !bus.clear && $onehot(bus.hitout);
    assign invalid   = bus.hit_valid && !bus.clear && !$onehot(bus.hitout);
    // half_q counts remaining halves down; even counts are the "off" halves,
    // so loading 2*BLINK_PERIODS starts with an off half.
    assign blink_off = (half_q != '0) && !half_q[0];

    // Next-state: scan prescaler/index, blink timer, history and registered outputs.
    always_comb begin
        hist_d      = hist_q;
        scan_cnt_d  = scan_cnt_q;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        half_d      = half_q;
        err_d       = invalid;
        dig_n_d     = '1;
        led_d       = 8'hFF;

        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end

        if (half_q != '0) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                half_d      = half_q - 1'b1;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        if (bus.clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) hist_d[i] = 3'd0;
            half_d      = '0;
            blink_cnt_d = '0;
        end else if (accept) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
            hist_d[0]   = encode(bus.hitout);
            half_d      = HALF_LOAD;
            blink_cnt_d = '0;
        end

        for (int k = 0; k < NUM_DIGITS; k++) dig_n_d[k] = (idx_q != IDX_W'(k));
        led_d = (idx_q == '0 && blink_off) ? 8'hFF : glyph(hist_q[idx_q]);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) hist_q[i] <= 3'd0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            half_q      <= '0;
            led_q       <= 8'hFF;
            dig_n_q     <= '1;
            err_q       <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            half_q      <= half_d;
            led_q       <= led_d;
            dig_n_q     <= dig_n_d;
            err_q       <= err_d;
        end
    end

    assign bus.batter_led = led_q;
    assign bus.dig_n      = dig_n_q;
    assign bus.err        = err_q;
endmodule
